// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Execute-stage load/store unit in front of a single-cycle,
//            word-addressed data memory. Handles byte/half/word loads with
//            sign or zero extension, word stores as a single write, and
//            byte/half stores as read-modify-write. One request in flight.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req_*                 - request channel (valid/ready handshake)
//            resp_*                - writeback channel (valid/ready handshake)
//            mem_*                 - downstream memory (combinational read)
// Config   : LSU_MISALIGN_TRAP_EN  - when defined, misaligned half/word
//                                    accesses fault instead of being
//                                    truncated to natural alignment.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_store,
  output logic        resp_fault,
  output logic        mem_active,
  output logic        mem_rw,
  output logic [31:0] mem_index,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0]  c_IDLE      = 2'd0;
  localparam logic [1:0]  c_READ      = 2'd1;
  localparam logic [1:0]  c_WRITE     = 2'd2;
  localparam logic [1:0]  c_RESP      = 2'd3;
  localparam logic [1:0]  c_SIZE_BYTE = 2'b00;
  localparam logic [1:0]  c_SIZE_HALF = 2'b01;
  localparam logic [1:0]  c_SIZE_WORD = 2'b10;
  localparam logic [1:0]  c_SIZE_RSVD = 2'b11;
  localparam logic [31:0] c_MEM_WORDS = 32'(MEM_WORDS);

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic        r_reqStore;
  logic [1:0]  r_reqSize;
  logic        r_reqSigned;
  logic [31:0] r_reqAddr;
  logic [4:0]  r_reqRd;
  logic        r_reqFault;
  logic [31:0] r_memWdata;
  logic [31:0] r_respData;

  logic        w_accept;
  logic        w_outOfRange;
  logic        w_reqFault;
  logic [31:0] w_alignedAddr;
  logic [7:0]  w_byteLane;
  logic [15:0] w_halfLane;
  logic [31:0] w_loadData;
  logic [31:0] w_mergedWord;

  assign w_accept     = req_valid && (r_state == c_IDLE);
  assign w_outOfRange = {2'b00, req_addr[31:2]} >= c_MEM_WORDS;

  // Halves and words are forced to natural alignment; with the trap enabled
  // a misaligned request faults before this address is ever used.
  always_comb begin
    w_alignedAddr = req_addr;
    if (req_size == c_SIZE_HALF) begin
      w_alignedAddr = {req_addr[31:1], 1'b0};
    end else if (req_size == c_SIZE_WORD) begin
      w_alignedAddr = {req_addr[31:2], 2'b00};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = ((req_size == c_SIZE_HALF) && req_addr[0]) ||
                        ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00));
  assign w_reqFault   = w_outOfRange || (req_size == c_SIZE_RSVD) || w_misaligned;
`else
  assign w_reqFault   = w_outOfRange || (req_size == c_SIZE_RSVD);
`endif

  // Little-endian lane extraction / insertion on the word read in READ.
  assign w_byteLane = mem_rdata[{r_reqAddr[1:0], 3'b000} +: 8];
  assign w_halfLane = mem_rdata[{r_reqAddr[1], 4'b0000} +: 16];

  always_comb begin
    w_loadData   = mem_rdata;
    w_mergedWord = mem_rdata;
    case (r_reqSize)
      c_SIZE_BYTE: begin
        w_loadData = {{24{r_reqSigned & w_byteLane[7]}}, w_byteLane};
        w_mergedWord[{r_reqAddr[1:0], 3'b000} +: 8] = r_memWdata[7:0];
      end
      c_SIZE_HALF: begin
        w_loadData = {{16{r_reqSigned & w_halfLane[15]}}, w_halfLane};
        w_mergedWord[{r_reqAddr[1], 4'b0000} +: 16] = r_memWdata[15:0];
      end
      default: begin
        w_loadData   = mem_rdata;
        w_mergedWord = mem_rdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE: begin
        if (req_valid) begin
          if (w_reqFault) begin
            w_nextState = c_RESP;
          end else if (req_store && (req_size == c_SIZE_WORD)) begin
            w_nextState = c_WRITE;
          end else begin
            // loads, and the read half of a sub-word read-modify-write
            w_nextState = c_READ;
          end
        end
      end
      c_READ:  w_nextState = r_reqStore ? c_WRITE : c_RESP;
      c_WRITE: w_nextState = c_RESP;
      c_RESP:  w_nextState = resp_ready ? c_IDLE : c_RESP;
      default: w_nextState = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_active = 1'b0;
    mem_rw     = 1'b0;
    mem_index  = 32'h0;
    mem_wdata  = 32'h0;
    case (r_state)
      c_IDLE: req_ready = 1'b1;
      c_READ: begin
        mem_active = 1'b1;
        mem_index  = {2'b00, r_reqAddr[31:2]};
      end
      c_WRITE: begin
        mem_active = 1'b1;
        mem_rw     = 1'b1;
        mem_index  = {2'b00, r_reqAddr[31:2]};
        mem_wdata  = r_memWdata;
      end
      c_RESP:  resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request capture and data path. r_memWdata first holds the right-aligned
  // store data, then is replaced by the merged word at the end of READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reqStore  <= 1'b0;
      r_reqSize   <= 2'b00;
      r_reqSigned <= 1'b0;
      r_reqAddr   <= 32'h0;
      r_reqRd     <= 5'h0;
      r_reqFault  <= 1'b0;
      r_memWdata  <= 32'h0;
      r_respData  <= 32'h0;
    end else if (w_accept) begin
      r_reqStore  <= req_store;
      r_reqSize   <= req_size;
      r_reqSigned <= req_signed;
      r_reqAddr   <= w_alignedAddr;
      r_reqRd     <= req_rd;
      r_reqFault  <= w_reqFault;
      r_memWdata  <= req_wdata;
      r_respData  <= 32'h0;
    end else if (r_state == c_READ) begin
      if (r_reqStore) begin
        r_memWdata <= w_mergedWord;
      end else begin
        r_respData <= w_loadData;
      end
    end
  end

  assign resp_data  = r_respData;
  assign resp_rd    = r_reqRd;
  assign resp_store = r_reqStore;
  assign resp_fault = r_reqFault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit. A behavioural memory
//            serves the DUT; a separate reference memory plus an arithmetic
//            access model predicts every response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int MW = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready, resp_store, resp_fault;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mem_active, mem_rw;
  logic [31:0] mem_index, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_store(resp_store), .resp_fault(resp_fault),
    .mem_active(mem_active), .mem_rw(mem_rw), .mem_index(mem_index),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- behavioural data memory (environment) ----------------
  logic [31:0] memArr [MW];
  logic        memLoadEn = 1'b0;
  logic [8:0]  memLoadIdx = '0;
  logic [31:0] memLoadVal = '0;

  assign mem_rdata = (mem_index < 32'(MW)) ? memArr[mem_index[8:0]] : 32'h0;

  always @(posedge clk) begin
    if (memLoadEn) memArr[memLoadIdx] <= memLoadVal;
    else if (mem_active && mem_rw && (mem_index < 32'(MW))) memArr[mem_index[8:0]] <= mem_wdata;
  end

  // ---------------- reference model ----------------
  logic [31:0] refMem [MW];

  logic        eFault;
  logic [31:0] eData, eIndex, eWdata;
  int          eLat, eReads, eWrites;

  task automatic model(input logic st, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] a, w, mask;
    int sh;
    eFault = ((addr >> 2) >= 32'(MW)) || (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)) eFault = 1'b1;
`endif
    a = (sz == 2'd1) ? (addr & ~32'd1) : (sz == 2'd2) ? (addr & ~32'd3) : addr;
    eIndex = a >> 2;
    sh = int'(a % 4) * 8;
    eData = 0; eWdata = 0; eReads = 0; eWrites = 0; eLat = 1;
    if (eFault) return;
    w = refMem[eIndex];
    if (!st) begin
      eReads = 1; eLat = 2;
      if (sz == 2'd2) eData = w;
      else if (sz == 2'd1) begin
        eData = (w >> sh) & 32'hFFFF;
        if (sgn && eData >= 32'h8000) eData = eData | 32'hFFFF0000;
      end else begin
        eData = (w >> sh) & 32'hFF;
        if (sgn && eData >= 32'h80) eData = eData | 32'hFFFFFF00;
      end
    end else begin
      eWrites = 1;
      if (sz == 2'd2) begin
        eWdata = wd; eLat = 2;
      end else begin
        eReads = 1; eLat = 3;
        mask   = ((sz == 2'd1) ? 32'hFFFF : 32'hFF) << sh;
        eWdata = (w & ~mask) | ((wd << sh) & mask);
      end
      refMem[eIndex] = eWdata;
    end
  endtask

  // ---------------- driver ----------------
  logic        gReadyOk, gTimeout, gOrderOk, gFault, gStore;
  logic [31:0] gData, gIndex, gWdata;
  logic [4:0]  gRd;
  int          gLat, gReads, gWrites;

  task automatic preload(input int idx, input logic [31:0] val);
    memLoadEn = 1'b1; memLoadIdx = idx[8:0]; memLoadVal = val;
    refMem[idx] = val;
    @(negedge clk);
    memLoadEn = 1'b0;
  endtask

  // Issues one request in the cycle after the previous response and follows
  // it until resp_valid, recording every memory cycle seen on the way.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    gReadyOk = req_ready;
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    gLat = 0; gReads = 0; gWrites = 0; gOrderOk = 1'b1; gTimeout = 1'b1;
    gIndex = '0; gWdata = '0;
    for (int k = 1; k <= 10; k++) begin
      if (mem_active) begin
        gIndex = mem_index;
        if (mem_rw) begin gWrites++; gWdata = mem_wdata; end
        else begin if (gWrites != 0) gOrderOk = 1'b0; gReads++; end
      end
      if (resp_valid) begin
        gLat = k; gTimeout = 1'b0;
        gData = resp_data; gFault = resp_fault; gStore = resp_store; gRd = resp_rd;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; req_store = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({resp_valid, resp_store, resp_fault, mem_active, mem_rw} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {resp_valid, resp_store, resp_fault, mem_active, mem_rw});
    end
    checks++;
    if (resp_data !== 32'h0 || resp_rd !== 5'h0) begin
      errors++; $display("FAIL reset_resp data=%h rd=%h want 0", resp_data, resp_rd);
    end
    checks++;
    if (mem_index !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem index=%h wdata=%h want 0", mem_index, mem_wdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    for (int i = 0; i < MW; i++) preload(i, $urandom);
    reset = 1'b0;
  endtask

  task automatic test_word;
    model(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, 5'd3);
    checks++;
    if (gLat != 2 || gFault !== 1'b0 || gStore !== 1'b1 || gData !== 32'h0 || gRd !== 5'd3) begin
      errors++; $display("FAIL word_store_resp lat=%0d fault=%b store=%b data=%h rd=%0d want 2/0/1/0/3", gLat, gFault, gStore, gData, gRd);
    end
    checks++;
    if (gWrites != 1 || gReads != 0 || gIndex !== 32'd2 || gWdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_store_mem wr=%0d rd=%0d idx=%0d wdata=%h want 1/0/2/deadbeef", gWrites, gReads, gIndex, gWdata);
    end
    model(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5'd4);
    checks++;
    if (gLat != 2 || gData !== 32'hDEADBEEF || gReads != 1 || gWrites != 0 || gIndex !== 32'd2 || gStore !== 1'b0) begin
      errors++; $display("FAIL word_load lat=%0d data=%h rd=%0d wr=%0d idx=%0d want 2/deadbeef/1/0/2", gLat, gData, gReads, gWrites, gIndex);
    end
  endtask

  task automatic test_rmw;
    preload(2, 32'h11223344);
    model(1'b1, 2'd0, 1'b0, 32'h9, 32'hA5);
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'hA5, 5'd7);
    checks++;
    if (gLat != 3 || gReads != 1 || gWrites != 1 || !gOrderOk || gWdata !== 32'h1122A544 || gIndex !== 32'd2) begin
      errors++; $display("FAIL rmw_store lat=%0d rd=%0d wr=%0d order=%b wdata=%h idx=%0d want 3/1/1/1/1122a544/2", gLat, gReads, gWrites, gOrderOk, gWdata, gIndex);
    end
    model(1'b0, 2'd0, 1'b1, 32'h9, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, 5'd8);
    checks++;
    if (gData !== 32'hFFFFFFA5 || gLat != 2) begin
      errors++; $display("FAIL signed_byte_load data=%h lat=%0d want ffffffa5/2", gData, gLat);
    end
  endtask

  task automatic test_fault;
    model(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h800, 32'h0, 5'd1);
    checks++;
    if (gLat != 1 || gFault !== 1'b1 || gReads + gWrites != 0 || gData !== 32'h0) begin
      errors++; $display("FAIL range_fault lat=%0d fault=%b memcyc=%0d data=%h want 1/1/0/0", gLat, gFault, gReads + gWrites, gData);
    end
    model(1'b1, 2'd3, 1'b0, 32'h4, 32'h12345678);
    do_req(1'b1, 2'd3, 1'b0, 32'h4, 32'h12345678, 5'd2);
    checks++;
    if (gLat != 1 || gFault !== 1'b1 || gReads + gWrites != 0 || gStore !== 1'b1) begin
      errors++; $display("FAIL size_fault lat=%0d fault=%b memcyc=%0d store=%b want 1/1/0/1", gLat, gFault, gReads + gWrites, gStore);
    end
  endtask

  task automatic test_stall;
    logic [31:0] expData;
    model(1'b0, 2'd1, 1'b0, 32'h6, 32'h0);
    expData = eData;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h6; req_rd = 5'd9;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== expData || resp_rd !== 5'd9 || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d valid=%b data=%h rd=%0d ready=%b want 1/%h/9/0", k, resp_valid, resp_data, resp_rd, req_ready, expData);
      end
      // stray store presented while busy must be ignored
      req_valid = (k < 3); req_store = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = $urandom;
      if (k == 3) resp_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release valid=%b ready=%b want 0/1", resp_valid, req_ready);
    end
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd10);
    checks++;
    if (gData !== eData) begin
      errors++; $display("FAIL ignored_store data=%h want %h", gData, eData);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h5A; req_rd = 5'd11;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_active !== 1'b1 || mem_rw !== 1'b0) begin
      errors++; $display("FAIL rmw_read_phase active=%b rw=%b want 1/0", mem_active, mem_rw);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_store, resp_fault, mem_active, mem_rw} !== 5'b0 || resp_data !== 32'h0 ||
        resp_rd !== 5'h0 || mem_index !== 32'h0 || mem_wdata !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_read flags=%b data=%h rd=%h idx=%h wd=%h ready=%b want all 0, ready 1",
                         {resp_valid, resp_store, resp_fault, mem_active, mem_rw}, resp_data, resp_rd, mem_index, mem_wdata, req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_active !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_write active=%b valid=%b want 0/0", mem_active, resp_valid);
    end
    model(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 5'd12);
    checks++;
    if (gData !== eData) begin
      errors++; $display("FAIL reset_mem_intact data=%h want %h", gData, eData);
    end
    // reset during WRITE: the write cycle already issued stands, nothing follows
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_addr = 32'h18; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_active !== 1'b0 || mem_rw !== 1'b0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_in_write active=%b rw=%b wdata=%h want 0/0/0", mem_active, mem_rw, mem_wdata);
    end
    refMem[6] = 32'hCAFEF00D;
    reset = 1'b0;
  endtask

  task automatic test_misalign;
    model(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 5'd13);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (gFault !== 1'b1 || gLat != 1 || gReads + gWrites != 0) begin
      errors++; $display("FAIL misalign_trap fault=%b lat=%0d memcyc=%0d want 1/1/0", gFault, gLat, gReads + gWrites);
    end
`else
    checks++;
    if (gFault !== 1'b0 || gLat != 2 || gReads != 1 || gIndex !== 32'd1 || gData !== eData) begin
      errors++; $display("FAIL misalign_trunc fault=%b lat=%0d reads=%0d idx=%0d data=%h want 0/2/1/1/%h", gFault, gLat, gReads, gIndex, gData, eData);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic st, sgn;
    logic [1:0] sz;
    logic [31:0] addr, wd;
    logic [4:0] rd;
    int mode;
    for (int n = 0; n < 200; n++) begin
      st  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      mode = $urandom_range(0, 9);
      case (mode)
        0:       addr = 32'h800 + 32'($urandom_range(0, 4095));
        1:       addr = 32'h7FC + 32'($urandom_range(0, 3));
        2:       addr = $urandom;
        default: addr = 32'($urandom_range(0, 63));
      endcase
      wd = $urandom; rd = 5'($urandom);
      model(st, sz, sgn, addr, wd);
      do_req(st, sz, sgn, addr, wd, rd);
      checks++;
      if (gReadyOk !== 1'b1 || gTimeout) begin
        errors++; $display("FAIL rnd%0d_handshake ready=%b timeout=%b want 1/0", n, gReadyOk, gTimeout);
      end
      checks++;
      if (gLat != eLat || gFault !== eFault || gStore !== st || gRd !== rd || gData !== eData) begin
        errors++; $display("FAIL rnd%0d_resp st=%b sz=%0d a=%h lat=%0d f=%b s=%b rd=%0d d=%h want %0d/%b/%b/%0d/%h",
                           n, st, sz, addr, gLat, gFault, gStore, gRd, gData, eLat, eFault, st, rd, eData);
      end
      checks++;
      if (gReads != eReads || gWrites != eWrites || !gOrderOk ||
          ((gReads + gWrites != 0) && gIndex !== eIndex) || ((gWrites != 0) && gWdata !== eWdata)) begin
        errors++; $display("FAIL rnd%0d_mem a=%h reads=%0d writes=%0d order=%b idx=%0d wd=%h want %0d/%0d/1/%0d/%h",
                           n, addr, gReads, gWrites, gOrderOk, gIndex, gWdata, eReads, eWrites, eIndex, eWdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_rmw();
    test_fault();
    test_stall();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
